uart_rx_frame: RTL and testbench

Parametrised UART receive engine, successor to the fixed 8-bit receiver. Adds configurable data width, one or two stop bits, 3-sample majority voting per bit, an input synchroniser, separate error pulses, and post-reset line arming. Sits between the `RX_IN` pad and the register or FIFO layer. Produces one validated word per frame on `P_DATA` with a `Data_Valid` strobe.

---
 rtl/uart_rx_frame.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receive engine with input synchroniser, 3-sample majority
// voting, optional parity, 1/2 stop bits and post-reset arming. Define UART_RX_BREAK_DET_EN for break detection.
module uart_rx_frame #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP_BITS,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      Data_Valid,
  output logic                      Par_Err,
  output logic                      Stp_Err,
  output logic                      Busy,
  output logic                      Break_Det
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                    r_state;
  logic                      r_sync1;
  logic                      r_sync2;
  logic [1:0]                r_sync_primed;
  logic                      r_armed;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
  logic [IDX_W-1:0]          r_bit_idx;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic                      r_stop_bits;
  logic                      r_stop_idx;
  logic                      r_samp0;
  logic                      r_samp1;
  logic [DATA_WIDTH-1:0]     r_shadow;
  logic [DATA_WIDTH-1:0]     r_p_data;
  logic                      r_par_bad;
  logic                      r_stp_bad;
  logic                      r_data_valid;
  logic                      r_par_err;
  logic                      r_stp_err;
  logic                      r_busy;
`ifdef UART_RX_BREAK_DET_EN
  logic                      r_all_zero;
  logic                      r_break_det;
`endif

  logic                      w_rx_s;
  logic                      w_vote;
  logic                      w_vote_cyc;
  logic                      w_wrap;
  logic                      w_stp_now;
  logic                      w_final_stop;
  logic [PRESCALE_WIDTH-1:0] w_half;
  logic [PRESCALE_WIDTH-1:0] w_half_m1;
  logic [PRESCALE_WIDTH-1:0] w_half_p1;
  logic [PRESCALE_WIDTH-1:0] w_last;

  // r_sync_primed keeps the reset value of the synchroniser from arming the receiver,
  // so a line held low across reset is never mistaken for idle-then-start.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_sync_primed <= 2'b00;
    end else begin
      r_sync1       <= RX_IN;
      r_sync2       <= r_sync1;
      r_sync_primed <= {r_sync_primed[0], 1'b1};
    end
  end

  assign w_rx_s       = r_sync2;
  assign w_half       = r_prescale >> 1;
  assign w_half_m1    = w_half - PRESCALE_WIDTH'(1);
  assign w_half_p1    = w_half + PRESCALE_WIDTH'(1);
  assign w_last       = r_prescale - PRESCALE_WIDTH'(1);
  assign w_vote       = (r_samp0 & r_samp1) | (r_samp0 & w_rx_s) | (r_samp1 & w_rx_s);
  assign w_vote_cyc   = (r_edge_cnt == w_half_p1);
  assign w_wrap       = (r_edge_cnt == w_last);
  assign w_stp_now    = r_stp_bad | ~w_vote;
  assign w_final_stop = (r_stop_idx == r_stop_bits);

  // NOTE: every register here uses <= so all reads in this block see pre-edge values;
  // later assignments in the same cycle deliberately override earlier defaults.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_armed      <= 1'b0;
      r_prescale   <= '0;
      r_edge_cnt   <= '0;
      r_bit_idx    <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_stop_bits  <= 1'b0;
      r_stop_idx   <= 1'b0;
      r_samp0      <= 1'b1;
      r_samp1      <= 1'b1;
      r_shadow     <= '0;
      r_p_data     <= '0;
      r_par_bad    <= 1'b0;
      r_stp_bad    <= 1'b0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      r_busy       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      r_all_zero   <= 1'b1;
      r_break_det  <= 1'b0;
`endif
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      r_break_det  <= 1'b0;
`endif
      if (w_rx_s && r_sync_primed[1]) r_armed <= 1'b1;

      if (r_state != S_IDLE) begin
        r_edge_cnt <= w_wrap ? '0 : r_edge_cnt + PRESCALE_WIDTH'(1);
        if (r_edge_cnt == w_half_m1) r_samp0 <= w_rx_s;
        if (r_edge_cnt == w_half)    r_samp1 <= w_rx_s;
`ifdef UART_RX_BREAK_DET_EN
        if (w_vote_cyc) r_all_zero <= r_all_zero & ~w_vote;
`endif
      end

      case (r_state)
        S_IDLE: begin
          r_edge_cnt <= '0;
          r_bit_idx  <= '0;
          // The detection cycle itself is edge 0 of the start bit, so counting resumes at 1.
          if (r_armed && !w_rx_s) begin
            r_state     <= S_START;
            r_busy      <= 1'b1;
            r_edge_cnt  <= PRESCALE_WIDTH'(1);
            r_prescale  <= Prescale;
            r_par_en    <= PAR_EN;
            r_par_typ   <= PAR_TYP;
            r_stop_bits <= STOP_BITS;
            r_stop_idx  <= 1'b0;
            r_par_bad   <= 1'b0;
            r_stp_bad   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            r_all_zero  <= 1'b1;
`endif
          end
        end

        S_START: begin
          if (w_vote_cyc && w_vote) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_edge_cnt <= '0;
          end else if (w_wrap) begin
            r_state <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_vote_cyc) r_shadow <= {w_vote, r_shadow[DATA_WIDTH-1:1]};
          if (w_wrap) begin
            if (r_bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
              r_bit_idx <= '0;
              r_state   <= r_par_en ? S_PARITY : S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
          end
        end

        S_PARITY: begin
          if (w_vote_cyc && (w_vote != (^r_shadow ^ r_par_typ))) r_par_bad <= 1'b1;
          if (w_wrap) r_state <= S_STOP;
        end

        S_STOP: begin
          if (w_wrap) r_stop_idx <= 1'b1;
          // The final stop bit completes at its vote, not its wrap, to allow minimum-length stops.
          if (w_vote_cyc) begin
            if (!w_vote) r_stp_bad <= 1'b1;
            if (w_final_stop) begin
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
              r_edge_cnt <= '0;
              if (!r_par_bad && !w_stp_now) begin
                r_p_data     <= r_shadow;
                r_data_valid <= 1'b1;
              end else begin
                r_par_err <= r_par_bad;
                r_stp_err <= w_stp_now;
              end
`ifdef UART_RX_BREAK_DET_EN
              if (r_all_zero && !w_vote) begin
                r_break_det <= 1'b1;
                r_armed     <= 1'b0;
              end
`endif
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign P_DATA     = r_p_data;
  assign Data_Valid = r_data_valid;
  assign Par_Err    = r_par_err;
  assign Stp_Err    = r_stp_err;
  assign Busy       = r_busy;
`ifdef UART_RX_BREAK_DET_EN
  assign Break_Det  = r_break_det;
`else
  assign Break_Det  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: directed frames push expected completions into
// per-instance queues; negedge monitors pop and compare whenever a completion pulse appears.
`timescale 1ns/1ps
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx8;
  logic       rx7;
  logic       par_en;
  logic       par_typ;
  logic       stop_bits;
  logic [5:0] prescale;

  logic [7:0] p_data8;
  logic       dv8, pe8, se8, busy8, bd8;
  logic [6:0] p_data7;
  logic       dv7, pe7, se7, busy7, bd7;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       dv;
    logic       pe;
    logic       se;
    logic       bd;
    logic [8:0] data;
    int         cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q7[$];
  exp_t e8;
  exp_t e7;

`ifdef UART_RX_BREAK_DET_EN
  localparam logic BD_EXP = 1'b1;
`else
  localparam logic BD_EXP = 1'b0;
`endif

  uart_rx_frame #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut8 (
    .CLK(clk), .RST(rst), .RX_IN(rx8), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .STOP_BITS(stop_bits), .Prescale(prescale), .P_DATA(p_data8), .Data_Valid(dv8),
    .Par_Err(pe8), .Stp_Err(se8), .Busy(busy8), .Break_Det(bd8)
  );

  uart_rx_frame #(.DATA_WIDTH(7), .PRESCALE_WIDTH(6)) dut7 (
    .CLK(clk), .RST(rst), .RX_IN(rx7), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .STOP_BITS(stop_bits), .Prescale(prescale), .P_DATA(p_data7), .Data_Valid(dv7),
    .Par_Err(pe7), .Stp_Err(se7), .Busy(busy7), .Break_Det(bd7)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit sel7, input logic dv, input logic pe, input logic se,
                          input logic bd, input logic [8:0] d, input int c);
    exp_t e;
    e.dv = dv; e.pe = pe; e.se = se; e.bd = bd; e.data = d; e.cyc = c;
    if (sel7) q7.push_back(e);
    else      q8.push_back(e);
  endtask

  // Drives one frame bit-by-bit; the final bit lasts last_len cycles and one sample
  // (glitch_bit, glitch_off) may be inverted to exercise the majority vote.
  task automatic send_frame(input bit sel7, input int p, input int w, input logic [8:0] data,
                            input bit with_par, input logic par_bit, input int nstop,
                            input logic stop_val, input int last_len,
                            input int glitch_bit, input int glitch_off);
    logic [11:0] bits;
    int          nbits;
    int          len;
    logic        v;
    nbits = 1 + w + (with_par ? 1 : 0) + nstop;
    bits  = '0;
    for (int i = 0; i < w; i++) bits[1+i] = data[i];
    if (with_par) bits[1+w] = par_bit;
    for (int i = 0; i < nstop; i++) bits[nbits-nstop+i] = stop_val;
    for (int b = 0; b < nbits; b++) begin
      len = (b == nbits - 1) ? last_len : p;
      for (int j = 0; j < len; j++) begin
        v = bits[b];
        if (b == glitch_bit && j == glitch_off) v = ~v;
        if (sel7) rx7 = v;
        else      rx8 = v;
        tick(1);
      end
    end
    if (sel7) rx7 = 1'b1;
    else      rx8 = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst && (dv8 || pe8 || se8 || bd8)) begin
      if (q8.size() == 0) begin
        check("dut8 unexpected pulse", 32'({dv8, pe8, se8, bd8}), 32'd0);
      end else begin
        e8 = q8.pop_front();
        check("dut8 Data_Valid", 32'(dv8), 32'(e8.dv));
        check("dut8 Par_Err",    32'(pe8), 32'(e8.pe));
        check("dut8 Stp_Err",    32'(se8), 32'(e8.se));
        check("dut8 Break_Det",  32'(bd8), 32'(e8.bd));
        check("dut8 P_DATA",     32'(p_data8), 32'(e8.data));
        check("dut8 pulse cycle", 32'(cyc), 32'(e8.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (dv7 || pe7 || se7 || bd7)) begin
      if (q7.size() == 0) begin
        check("dut7 unexpected pulse", 32'({dv7, pe7, se7, bd7}), 32'd0);
      end else begin
        e7 = q7.pop_front();
        check("dut7 Data_Valid", 32'(dv7), 32'(e7.dv));
        check("dut7 Par_Err",    32'(pe7), 32'(e7.pe));
        check("dut7 Stp_Err",    32'(se7), 32'(e7.se));
        check("dut7 Break_Det",  32'(bd7), 32'(e7.bd));
        check("dut7 P_DATA",     32'(p_data7), 32'(e7.data));
        check("dut7 pulse cycle", 32'(cyc), 32'(e7.cyc));
      end
    end
  end

  initial begin
    int n;
    int bcnt;
    rst = 1'b1; rx8 = 1'b1; rx7 = 1'b1;
    par_en = 1'b0; par_typ = 1'b0; stop_bits = 1'b0; prescale = 6'd8;
    tick(3);
    check("reset P_DATA",     32'(p_data8), 32'd0);
    check("reset Data_Valid", 32'(dv8),     32'd0);
    check("reset Par_Err",    32'(pe8),     32'd0);
    check("reset Stp_Err",    32'(se8),     32'd0);
    check("reset Busy",       32'(busy8),   32'd0);
    check("reset Break_Det",  32'(bd8),     32'd0);
    rst = 1'b0;
    tick(10);

    // Basic frame: completion at S+78, S = n+2.
    n = cyc;
    push_exp(0, 1, 0, 0, 0, 9'h0A5, n + 80);
    send_frame(0, 8, 8, 9'h0A5, 0, 1'b0, 1, 1'b1, 8, -1, 0);
    tick(20);

    // Parity error: 0x3C has even weight, parity bit 1 is wrong; S+86; P_DATA keeps 0xA5.
    par_en = 1'b1; par_typ = 1'b0;
    n = cyc;
    push_exp(0, 0, 1, 0, 0, 9'h0A5, n + 88);
    send_frame(0, 8, 8, 9'h03C, 1, 1'b1, 1, 1'b1, 8, -1, 0);
    tick(20);
    par_en = 1'b0;

    // Start glitch: 3-cycle low pulse.
    rx8 = 1'b0;
    tick(3);
    rx8 = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy8) bcnt++;
      tick(1);
    end
    check("glitch busy within 1..8 cycles", 32'(bcnt >= 1 && bcnt <= 8), 32'd1);
    check("glitch busy released", 32'(busy8), 32'd0);

    // Stop error: stop bit driven low.
    n = cyc;
    push_exp(0, 0, 0, 1, 0, 9'h0A5, n + 80);
    send_frame(0, 8, 8, 9'h081, 0, 1'b0, 1, 1'b0, 8, -1, 0);
    tick(30);

    // One corrupted mid-sample in data bit 3 (frame bit 4) still votes correctly.
    n = cyc;
    push_exp(0, 1, 0, 0, 0, 9'h05A, n + 80);
    send_frame(0, 8, 8, 9'h05A, 0, 1'b0, 1, 1'b1, 8, 4, 4);
    tick(20);

    // Back-to-back on the 7-bit instance: odd parity, 2 stops, P=16, L=10 -> S+170.
    // The final stop of frame 1 is cut to 10 cycles so frame 2 starts at the earliest legal point.
    prescale = 6'd16; par_en = 1'b1; par_typ = 1'b1; stop_bits = 1'b1;
    n = cyc;
    push_exp(1, 1, 0, 0, 0, 9'h055, n + 172);
    send_frame(1, 16, 7, 9'h055, 1, 1'b1, 2, 1'b1, 10, -1, 0);
    n = cyc;
    push_exp(1, 1, 0, 0, 0, 9'h02A, n + 172);
    send_frame(1, 16, 7, 9'h02A, 1, 1'b0, 2, 1'b1, 16, -1, 0);
    tick(20);
    prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0; stop_bits = 1'b0;

    // Reset mid-frame with the line held low across reset.
    rx8 = 1'b0;
    tick(20);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(40);
    check("low line after reset: Busy", 32'(busy8), 32'd0);
    check("low line after reset: P_DATA cleared", 32'(p_data8), 32'd0);
    rx8 = 1'b1;
    tick(10);
    n = cyc;
    push_exp(0, 1, 0, 0, 0, 9'h0C3, n + 80);
    send_frame(0, 8, 8, 9'h0C3, 0, 1'b0, 1, 1'b1, 8, -1, 0);
    tick(20);

    // All-zero frame: Stp_Err always, Break_Det only when the feature is built in.
    n = cyc;
    push_exp(0, 0, 0, 1, BD_EXP, 9'h0C3, n + 80);
    send_frame(0, 8, 8, 9'h000, 0, 1'b0, 1, 1'b0, 8, -1, 0);
    tick(30);

    // Normal reception resumes after the line returns high.
    n = cyc;
    push_exp(0, 1, 0, 0, 0, 9'h096, n + 80);
    send_frame(0, 8, 8, 9'h096, 0, 1'b0, 1, 1'b1, 8, -1, 0);

    for (int i = 0; i < 2000 && (q8.size() != 0 || q7.size() != 0); i++) tick(1);
    check("dut8 expectations outstanding", 32'(q8.size()), 32'd0);
    check("dut7 expectations outstanding", 32'(q7.size()), 32'd0);
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
